sa_result_drain: RTL and testbench
==================================

// Module: sa_result_drain
// PURPOSE
//  Output-side collector for the systolic array: snapshots the flattened PE result bus Y
//  on a capture strobe and streams the HPE*VPE accumulators out one per beat over a
//  valid/ready interface. Sits between the array's Y port and the result sink.
//  Frees the array for the next tile while the previous tile drains.
// PARAMETERS
//  WIDTH  8  operand width; each result element is 2*WIDTH bits
//  HPE    2  horizontal PE count
//  VPE    8  vertical PE count (N = HPE*VPE elements)
// PORTS
//  CLK         in   1             clock, rising edge
//  RST         in   1             async reset, active-low
//  Y_IN        in   2*WIDTH*N     flattened PE results; element e = Y_IN[(N-e)*2*WIDTH-1 -: 2*WIDTH]
//  cap         in   1             capture strobe (single-cycle request)
//  busy        out  1             snapshot held, drain in progress
//  out_data    out  2*WIDTH       current element
//  out_valid   out  1             out_data/out_row/out_col/out_last valid
//  out_ready   in   1             sink accepts beat when out_valid&&out_ready
//  out_row     out  $clog2(HPE)   e / VPE
//  out_col     out  $clog2(VPE)   e % VPE
//  out_last    out  1             high on element N-1
//  overrun     out  1             sticky: cap arrived while busy and was not accepted
//  clr_overrun in   1             synchronous clear of overrun
// BEHAVIOUR
//  - Reset (RST=0, async): state IDLE, busy=0, out_valid=0, out_data=0, out_row=0,
//    out_col=0, out_last=0, overrun=0, element pointer=0, snapshot cleared to 0.
//  - FSM states: IDLE, STREAM.
//  - IDLE: cap=1 -> register whole Y_IN into snapshot at that edge, ptr=0, go STREAM.
//    Next cycle out_valid=1 with element 0 (1-cycle latency cap->first beat).
//  - STREAM: outputs driven from registers, stable while out_valid&&!out_ready.
//    Beat accepted: ptr increments; outputs update next edge. out_last=1 iff ptr==N-1.
//  - Accept of last beat: cap same cycle -> re-snapshot, stay STREAM, element 0 valid
//    next cycle (back-to-back, no bubble). No cap -> IDLE, out_valid=0, busy=0.
//  - cap in STREAM other than on last-beat accept: ignored, snapshot untouched, overrun<=1.
//  - overrun: clr_overrun clears; clear and new overrun event same cycle -> overrun=1.
//  - busy = (state==STREAM).
//  - Ptr never wraps silently: only reset or last-beat accept returns it to 0.
//  - out_ready ignored when out_valid=0. cap while RST low has no effect.
//  - RST asserted mid-drain: immediate abort, all outputs to reset values; in-flight
//    elements lost; no partial resume after release.
//  - Data passed unmodified, except under the optional feature below.
// CONFIGURATION
//  SA_DRAIN_RELU_EN defined: element treated as signed 2*WIDTH; MSB=1 -> out_data=0,
//    else unchanged. Applied at snapshot time; ordering/handshake unchanged.
//  Not defined: out_data is raw bit copy of the Y_IN slice (no sign interpretation).
// TESTING (WIDTH=8, HPE=2, VPE=8, N=16)
//  1 Y_IN element e=16'h0100+e, cap pulse, out_ready=1 -> 16 beats on consecutive cycles
//    starting 1 cycle after cap: 0100..010F, row 0 for e<8 / 1 for e>=8, out_last on e=15.
//  2 Same snapshot, out_ready toggling 1,0,0,1... -> out_data held through stalls, no element
//    skipped or repeated, still 16 beats; Y_IN changed after cap does not affect output.
//  3 cap during beat 5 -> overrun=1, stream continues with original data; clr_overrun -> 0.
//  4 cap on cycle of last-beat accept, new Y_IN=16'hAA00+e -> element AA00 valid next cycle,
//    no idle cycle, overrun stays 0.
//  5 RST low at beat 7 -> out_valid=0, busy=0, outputs 0 same edge; new cap after release
//    starts at element 0.
//  6 Element 3 = 16'hFF80, rest 16'h0005: SA_DRAIN_RELU_EN -> beat 3 = 0000;
//    without macro -> beat 3 = FF80; all others 0005.

Source files
------------

// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots the flattened systolic-array result bus on a
// capture strobe and streams the N = HPE*VPE accumulators out one per beat
// over a valid/ready interface, so the array can start the next tile while
// the previous one drains.
//
// Optional feature: define SA_DRAIN_RELU_EN to clamp negative elements
// (signed 2*WIDTH, MSB set) to zero as they are snapshotted. Without the
// macro the snapshot is a raw bit copy of each Y_IN slice.
module sa_result_drain #(
    parameter int WIDTH = 8,
    parameter int HPE   = 2,
    parameter int VPE   = 8,
    localparam int N    = HPE * VPE,
    localparam int EW   = 2 * WIDTH,
    localparam int RW   = (HPE > 1) ? $clog2(HPE) : 1,
    localparam int CW   = (VPE > 1) ? $clog2(VPE) : 1,
    localparam int PW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [EW*N-1:0] Y_IN,
    input  logic            cap,
    output logic            busy,
    output logic [EW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_row,
    output logic [CW-1:0]   out_col,
    output logic            out_last,
    output logic            overrun,
    input  logic            clr_overrun
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            overrun_q, overrun_d;
    logic            load;
    logic            ovr_evt;
    logic            accept;
    logic            at_last;

    logic [EW-1:0]   y_elem [N];
    logic [EW-1:0]   snap_q [N];
    logic [EW-1:0]   snap_d [N];

    assign accept  = (state_q == S_STREAM) && out_ready;
    assign at_last = (ptr_q == PW'(N - 1));

    // Slice the flattened bus into elements (element 0 sits at the MSB end)
    // and apply the optional negative clamp on the way into the snapshot.
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
        logic [EW-1:0] raw;
        assign raw = Y_IN[(N - gi) * EW - 1 -: EW];
`ifdef SA_DRAIN_RELU_EN
        assign y_elem[gi] = raw[EW-1] ? '0 : raw;
`else
        assign y_elem[gi] = raw;
`endif

        // Snapshot element holds until a capture is accepted.
        always_comb begin
            snap_d[gi] = snap_q[gi];
            if (load) begin
                snap_d[gi] = y_elem[gi];
            end
        end

        // Snapshot element register, cleared on reset.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                snap_q[gi] <= '0;
            end else begin
                snap_q[gi] <= snap_d[gi];
            end
        end
    end

    // FSM state and element pointer registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: capture from idle, advance on accepted beats, and
    // allow a fresh capture on the very cycle the last beat leaves.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        ovr_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cap) begin
                    load    = 1'b1;
                    ptr_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept && at_last) begin
                    ptr_d = '0;
                    if (cap) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (accept) begin
                        ptr_d = ptr_q + PW'(1);
                    end
                    // A capture that cannot be honoured leaves the snapshot alone.
                    if (cap) begin
                        ovr_evt = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Output decode: everything comes straight from registered state, so
    // the beat is stable for as long as the sink stalls.
    always_comb begin
        busy      = (state_q == S_STREAM);
        out_valid = (state_q == S_STREAM);
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        if (state_q == S_STREAM) begin
            out_data = snap_q[ptr_q];
            out_row  = RW'(int'(ptr_q) / VPE);
            out_col  = CW'(int'(ptr_q) % VPE);
            out_last = at_last;
        end
    end

    // Sticky overrun flag; a new event wins over a same-cycle clear.
    always_comb begin
        overrun_d = overrun_q;
        if (ovr_evt) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // Overrun flag register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Testbench for sa_result_drain: random and directed tiles checked against a
// queue-based model of the expected beat sequence.
module tb_sa_result_drain;

    localparam int WIDTH = 8;
    localparam int HPE   = 2;
    localparam int VPE   = 8;
    localparam int N     = HPE * VPE;
    localparam int EW    = 2 * WIDTH;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [EW*N-1:0] Y_IN = '0;
    logic            cap = 1'b0;
    logic            out_ready = 1'b0;
    logic            clr_overrun = 1'b0;
    logic            busy;
    logic [EW-1:0]   out_data;
    logic            out_valid;
    logic [0:0]      out_row;
    logic [2:0]      out_col;
    logic            out_last;
    logic            overrun;

    int tests = 0;
    int fails = 0;

    logic [EW-1:0] exp_data_q[$];
    int            exp_idx_q[$];
    logic          exp_ovr = 1'b0;

    sa_result_drain #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Y_IN        (Y_IN),
        .cap         (cap),
        .busy        (busy),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [EW*N-1:0] pat_y(input int base);
        logic [EW*N-1:0] y;
        y = '0;
        for (int e = 0; e < N; e++) y[(N - e) * EW - 1 -: EW] = EW'(base + e);
        return y;
    endfunction

    function automatic logic [EW*N-1:0] rand_y();
        logic [EW*N-1:0] y;
        y = '0;
        for (int e = 0; e < N; e++) y[(N - e) * EW - 1 -: EW] = EW'($urandom);
        return y;
    endfunction

    // Expected value of an element after the optional negative clamp.
    function automatic logic [EW-1:0] model_val(input logic [EW-1:0] v);
`ifdef SA_DRAIN_RELU_EN
        return v[EW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_capture(input logic [EW*N-1:0] y);
        for (int e = 0; e < N; e++) begin
            exp_data_q.push_back(model_val(y[(N - e) * EW - 1 -: EW]));
            exp_idx_q.push_back(e);
        end
    endtask

    // Issue a capture from idle; the first beat is expected on the next cycle.
    task automatic start_capture(input logic [EW*N-1:0] y);
        Y_IN = y;
        cap = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge CLK);
        cap = 1'b0;
        model_capture(y);
    endtask

    // Drain the modelled queue. mode 0: always ready, 1: ready 1,0,0,1..., 2: random.
    // ovr_idx / clr_idx: element index at which a stray cap (with clear) is injected.
    // b2b: recapture y2 on the cycle the last beat is accepted.
    task automatic stream_run(input string tag, input int mode, input int ovr_idx,
                              input int clr_idx, input bit b2b, input logic [EW*N-1:0] y2);
        int   cyc;
        int   idx;
        bit   rdy;
        bit   pop_last;
        bit   evt;
        logic [0:0] er;
        logic [2:0] ec;
        cyc = 0;
        while (exp_data_q.size() > 0 && cyc < 400) begin
            idx = exp_idx_q[0];
            er = 1'(idx / VPE);
            ec = 3'(idx % VPE);
            tests++;
            if ({out_valid, busy, out_data, out_row, out_col, out_last} !==
                {2'b11, exp_data_q[0], er, ec, (idx == N - 1)}) begin
                fails++;
                $display("FAIL %s beat e=%0d: got v=%b busy=%b d=%h row=%0d col=%0d last=%b, required v=1 busy=1 d=%h row=%0d col=%0d last=%b",
                         tag, idx, out_valid, busy, out_data, out_row, out_col, out_last,
                         exp_data_q[0], er, ec, (idx == N - 1));
            end
            tests++;
            if (overrun !== exp_ovr) begin
                fails++;
                $display("FAIL %s overrun e=%0d: got %b required %b", tag, idx, overrun, exp_ovr);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            cap = 1'b0;
            clr_overrun = 1'b0;
            Y_IN = rand_y();
            if (idx == ovr_idx) cap = 1'b1;
            if (idx == clr_idx) begin
                cap = 1'b1;
                clr_overrun = 1'b1;
            end
            pop_last = rdy && (idx == N - 1);
            if (b2b && pop_last) begin
                cap = 1'b1;
                Y_IN = y2;
            end
            evt = cap && !pop_last;
            if (evt) exp_ovr = 1'b1;
            else if (clr_overrun) exp_ovr = 1'b0;
            if (rdy) begin
                void'(exp_data_q.pop_front());
                void'(exp_idx_q.pop_front());
            end
            if (b2b && pop_last) begin
                model_capture(y2);
                b2b = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        cap = 1'b0;
        clr_overrun = 1'b0;
        out_ready = 1'b0;
        if (exp_data_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got %0d beats outstanding required 0", tag, exp_data_q.size());
            exp_data_q.delete();
            exp_idx_q.delete();
        end
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL %s idle after drain: got v=%b busy=%b required v=0 busy=0", tag, out_valid, busy);
        end
        tests++;
        if (overrun !== exp_ovr) begin
            fails++;
            $display("FAIL %s overrun after drain: got %b required %b", tag, overrun, exp_ovr);
        end
        $display("[TB] %s: tile drained, overrun=%b", tag, overrun);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        cap = 1'b1;
        Y_IN = rand_y();
        out_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if ({busy, out_valid, out_data, out_row, out_col, out_last, overrun} !== '0) begin
            fails++;
            $display("FAIL reset outputs: got busy=%b v=%b d=%h row=%0d col=%0d last=%b ovr=%b required all 0",
                     busy, out_valid, out_data, out_row, out_col, out_last, overrun);
        end
        RST = 1'b1;
        cap = 1'b0;
        out_ready = 1'b0;
        @(negedge CLK);
        tests++;
        if ({busy, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset cap ignored: got busy=%b v=%b required 0 0", busy, out_valid);
        end
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_basic();
        start_capture(pat_y(16'h0100));
        stream_run("basic", 0, -1, -1, 1'b0, '0);
    endtask

    task automatic test_stall();
        start_capture(pat_y(16'h0100));
        stream_run("stall", 1, -1, -1, 1'b0, '0);
    endtask

    task automatic test_overrun();
        start_capture(rand_y());
        stream_run("overrun", 0, 5, 9, 1'b0, '0);
        clr_overrun = 1'b1;
        exp_ovr = 1'b0;
        @(negedge CLK);
        clr_overrun = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun clear: got %b required 0", overrun);
        end
        $display("[TB] overrun: cleared, overrun=%b", overrun);
    endtask

    task automatic test_back_to_back();
        start_capture(rand_y());
        stream_run("back_to_back", 0, -1, -1, 1'b1, pat_y(16'hAA00));
    endtask

    task automatic test_reset_mid_drain();
        logic [EW-1:0] e7;
        start_capture(pat_y(16'h0300));
        out_ready = 1'b1;
        repeat (7) @(negedge CLK);
        e7 = exp_data_q[7];
        tests++;
        if ({out_valid, out_data} !== {1'b1, e7}) begin
            fails++;
            $display("FAIL reset_mid beat7: got v=%b d=%h required v=1 d=%h", out_valid, out_data, e7);
        end
        RST = 1'b0;
        #1;
        tests++;
        if ({busy, out_valid, out_data, out_row, out_col, out_last, overrun} !== '0) begin
            fails++;
            $display("FAIL reset_mid abort: got busy=%b v=%b d=%h row=%0d col=%0d last=%b ovr=%b required all 0",
                     busy, out_valid, out_data, out_row, out_col, out_last, overrun);
        end
        exp_data_q.delete();
        exp_idx_q.delete();
        exp_ovr = 1'b0;
        out_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        tests++;
        if ({busy, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_mid resume: got busy=%b v=%b required 0 0", busy, out_valid);
        end
        $display("[TB] reset_mid_drain: aborted at beat 7");
        start_capture(pat_y(16'h0500));
        stream_run("after_reset", 0, -1, -1, 1'b0, '0);
    endtask

    task automatic test_relu_pattern();
        logic [EW*N-1:0] y;
        y = pat_y(0);
        for (int e = 0; e < N; e++) y[(N - e) * EW - 1 -: EW] = (e == 3) ? 16'hFF80 : 16'h0005;
        start_capture(y);
        stream_run("relu_pattern", 0, -1, -1, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            start_capture(rand_y());
            stream_run("random", 2, -1, -1, 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid_drain();
        test_relu_pattern();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
